// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state and grant encodings for the RAM port arbiter
package ram_arb_pkg;
   typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, RD_DONE} state_t;
   typedef enum logic {GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on conflict the side not granted last wins
module rr_arbiter_2
   import ram_arb_pkg::*;
(
   input  logic   wr_req,
   input  logic   rd_req,
   input  grant_t last_gnt,
   output grant_t gnt
);
   always_comb
      gnt = (wr_req && rd_req) ? ((last_gnt == GNT_WR) ? GNT_RD : GNT_WR)
                               : (wr_req ? GNT_WR : GNT_RD);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between a write and a read requester
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int SIZE_ADDR = 4,
   parameter int SIZE_DATA = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wr_req,
   input  logic [SIZE_ADDR-1:0] i_wr_addr,
   input  logic [SIZE_DATA-1:0] i_wr_data,
   output logic                 o_wr_ack,
   input  logic                 i_rd_req,
   input  logic [SIZE_ADDR-1:0] i_rd_addr,
   output logic [SIZE_DATA-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_ram_wr_en,
   output logic                 o_ram_rd_en,
   output logic [SIZE_ADDR-1:0] o_ram_addr,
   output logic [SIZE_DATA-1:0] o_ram_data,
   input  logic [SIZE_DATA-1:0] i_ram_data,
   output logic                 o_busy
);
   state_t                 state, state_nxt;
   grant_t                 last_gnt, gnt;
   logic                   grant_en;
   logic [SIZE_ADDR-1:0]   addr_q;
   logic [SIZE_DATA-1:0]   data_q;

   rr_arbiter_2 u_rr (
      .wr_req   (i_wr_req),
      .rd_req   (i_rd_req),
      .last_gnt (last_gnt),
      .gnt      (gnt)
   );

   assign grant_en = (state == IDLE) && (i_wr_req || i_rd_req);

   // last_gnt resets to read so the first conflict goes to the writer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         last_gnt  <= GNT_RD;
         addr_q    <= '0;
         data_q    <= '0;
         o_rd_data <= '0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            last_gnt <= gnt;
            addr_q   <= (gnt == GNT_WR) ? i_wr_addr : i_rd_addr;
            if (gnt == GNT_WR) data_q <= i_wr_data;
         end
         if (state == RD_WAIT) o_rd_data <= i_ram_data;
      end
   end

   always_comb begin
      state_nxt   = IDLE;
      o_ram_wr_en = 1'b0;
      o_ram_rd_en = 1'b0;
      o_wr_ack    = 1'b0;
      o_rd_valid  = 1'b0;
      o_ram_addr  = '0;
      o_ram_data  = '0;
      o_busy      = (state != IDLE);
      case (state)
         IDLE:    state_nxt = grant_en ? ((gnt == GNT_WR) ? WRITE : READ) : IDLE;
         WRITE: begin
            o_ram_wr_en = 1'b1;
            o_wr_ack    = 1'b1;
            o_ram_addr  = addr_q;
            o_ram_data  = data_q;
         end
         READ: begin
            state_nxt   = RD_WAIT;
            o_ram_rd_en = 1'b1;
            o_ram_addr  = addr_q;
         end
         RD_WAIT: state_nxt = RD_DONE;
         RD_DONE: o_rd_valid = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed tests of ram_port_arbiter against a behavioural RAM
module tb_ram_port_arbiter;
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_wr_req = 1'b0;
   logic [3:0] i_wr_addr = '0;
   logic [7:0] i_wr_data = '0;
   logic       o_wr_ack;
   logic       i_rd_req = 1'b0;
   logic [3:0] i_rd_addr = '0;
   logic [7:0] o_rd_data;
   logic       o_rd_valid;
   logic       o_ram_wr_en;
   logic       o_ram_rd_en;
   logic [3:0] o_ram_addr;
   logic [7:0] o_ram_data;
   logic [7:0] i_ram_data;
   logic       o_busy;
   logic [7:0] mem [16];
   logic [7:0] ram_q = '0;
   logic       mon_en = 1'b0;
   int         checks = 0;
   int         errors = 0;

   ram_port_arbiter #(.SIZE_ADDR(4), .SIZE_DATA(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
      .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
      .o_ram_wr_en(o_ram_wr_en), .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr),
      .o_ram_data(o_ram_data), .i_ram_data(i_ram_data), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   // synchronous RAM: read data appears the cycle after the rd_en edge
   always @(posedge i_clk) begin
      if (o_ram_wr_en) mem[o_ram_addr] <= o_ram_data;
      if (o_ram_rd_en) ram_q <= mem[o_ram_addr];
   end
   assign i_ram_data = ram_q;

   always @(negedge i_clk) begin
      if (mon_en) begin
         checks++;
         if ((o_ram_wr_en | o_wr_ack) & (o_ram_rd_en | o_rd_valid)) begin
            errors++;
            $display("FAIL strobe_overlap: wr_en=%b ack=%b rd_en=%b valid=%b, want no write/read overlap",
                     o_ram_wr_en, o_wr_ack, o_ram_rd_en, o_rd_valid);
         end
      end
   end

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge i_clk);
      i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d;
      @(posedge i_clk);
      #1 i_wr_req = 1'b0; i_wr_addr = ~a; i_wr_data = ~d;
      @(negedge i_clk);
      checks++;
      if ({o_ram_wr_en, o_wr_ack, o_ram_rd_en, o_rd_valid, o_ram_addr, o_ram_data, o_busy} !== {4'b1100, a, d, 1'b1}) begin
         errors++;
         $display("FAIL write_cycle a=%0d: got wr_en=%b ack=%b rd_en=%b valid=%b addr=%h data=%h busy=%b, want 1 1 0 0 %h %h 1",
                  a, o_ram_wr_en, o_wr_ack, o_ram_rd_en, o_rd_valid, o_ram_addr, o_ram_data, o_busy, a, d);
      end
      @(negedge i_clk);
      checks++;
      if ({o_ram_wr_en, o_wr_ack, o_ram_addr, o_ram_data, o_busy} !== 15'd0) begin
         errors++;
         $display("FAIL write_idle a=%0d: got wr_en=%b ack=%b addr=%h data=%h busy=%b, want all 0",
                  a, o_ram_wr_en, o_wr_ack, o_ram_addr, o_ram_data, o_busy);
      end
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] d);
      @(negedge i_clk);
      i_rd_req = 1'b1; i_rd_addr = a;
      @(posedge i_clk);
      #1 i_rd_req = 1'b0; i_rd_addr = ~a;
      @(negedge i_clk);
      checks++;
      if ({o_ram_rd_en, o_ram_wr_en, o_rd_valid, o_ram_addr, o_ram_data, o_busy} !== {3'b100, a, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL read_strobe a=%0d: got rd_en=%b wr_en=%b valid=%b addr=%h data=%h busy=%b, want 1 0 0 %h 00 1",
                  a, o_ram_rd_en, o_ram_wr_en, o_rd_valid, o_ram_addr, o_ram_data, o_busy, a);
      end
      @(negedge i_clk);
      checks++;
      if ({o_ram_rd_en, o_rd_valid, o_ram_addr, o_busy} !== {2'b00, 4'h0, 1'b1}) begin
         errors++;
         $display("FAIL read_wait a=%0d: got rd_en=%b valid=%b addr=%h busy=%b, want 0 0 0 1",
                  a, o_ram_rd_en, o_rd_valid, o_ram_addr, o_busy);
      end
      @(negedge i_clk);
      checks++;
      if ({o_rd_valid, o_rd_data, o_busy} !== {1'b1, d, 1'b1}) begin
         errors++;
         $display("FAIL read_valid a=%0d: got valid=%b data=%h busy=%b, want 1 %h 1", a, o_rd_valid, o_rd_data, o_busy, d);
      end
      @(negedge i_clk);
      checks++;
      if ({o_rd_valid, o_rd_data, o_busy} !== {1'b0, d, 1'b0}) begin
         errors++;
         $display("FAIL read_hold a=%0d: got valid=%b data=%h busy=%b, want 0 %h 0", a, o_rd_valid, o_rd_data, o_busy, d);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_wr_req = 1'b1; i_rd_req = 1'b1; i_wr_addr = 4'h7; i_wr_data = 8'hC3; i_rd_addr = 4'h9;
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_wr_ack, o_rd_data, o_rd_valid, o_ram_wr_en, o_ram_rd_en, o_ram_addr, o_ram_data, o_busy} !== 27'd0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b rdata=%h valid=%b wr_en=%b rd_en=%b addr=%h data=%h busy=%b, want all 0",
                  o_wr_ack, o_rd_data, o_rd_valid, o_ram_wr_en, o_ram_rd_en, o_ram_addr, o_ram_data, o_busy);
      end
      i_rst = 1'b0; i_wr_req = 1'b0; i_rd_req = 1'b0;
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b, want 0", o_busy);
      end
   endtask

   task automatic test_write();
      do_write(4'h3, 8'h0A);
   endtask

   task automatic test_read();
      do_read(4'h3, 8'h0A);
   endtask

   task automatic test_fairness();
      logic [4:0] exp_s [1:12];
      logic [4:0] s;
      logic [3:0] exp_a;
      // {wr_en, rd_en, wr_ack, rd_valid, busy}: W,idle,R,wait,done,idle,W,idle,R,wait,done,idle
      exp_s = '{5'b10101, 5'b00000, 5'b01001, 5'b00001, 5'b00011, 5'b00000,
                5'b10101, 5'b00000, 5'b01001, 5'b00001, 5'b00011, 5'b00000};
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      i_wr_req = 1'b1; i_rd_req = 1'b1; i_wr_addr = 4'h5; i_wr_data = 8'h33; i_rd_addr = 4'h5;
      for (int c = 1; c <= 12; c++) begin
         @(negedge i_clk);
         s = {o_ram_wr_en, o_ram_rd_en, o_wr_ack, o_rd_valid, o_busy};
         exp_a = (exp_s[c][4] | exp_s[c][3]) ? 4'h5 : 4'h0;
         checks++;
         if ({s, o_ram_addr} !== {exp_s[c], exp_a}) begin
            errors++;
            $display("FAIL fair_cycle%0d: got strobes=%b addr=%h, want %b %h", c, s, o_ram_addr, exp_s[c], exp_a);
         end
         if (c == 5 || c == 11) begin
            checks++;
            if (o_rd_data !== 8'h33) begin
               errors++;
               $display("FAIL fair_rdata%0d: got %h, want 33", c, o_rd_data);
            end
         end
         if (c == 11) begin
            i_wr_req = 1'b0; i_rd_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic seen;
      @(negedge i_clk);
      i_rd_req = 1'b1; i_rd_addr = 4'h3;
      @(posedge i_clk);
      #1 i_rd_req = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      checks++;
      if ({o_busy, o_ram_rd_en, o_rd_valid} !== 3'b100) begin
         errors++;
         $display("FAIL midrd_wait: got busy=%b rd_en=%b valid=%b, want 1 0 0", o_busy, o_ram_rd_en, o_rd_valid);
      end
      #1 i_rst = 1'b1;
      #1;
      checks++;
      if ({o_wr_ack, o_rd_data, o_rd_valid, o_ram_wr_en, o_ram_rd_en, o_ram_addr, o_ram_data, o_busy} !== 27'd0) begin
         errors++;
         $display("FAIL midrd_async_reset: got rdata=%h valid=%b busy=%b addr=%h, want all 0",
                  o_rd_data, o_rd_valid, o_busy, o_ram_addr);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge i_clk);
         seen |= o_rd_valid | o_busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midrd_no_valid: got valid_or_busy_seen=%b, want 0", seen);
      end
      do_read(4'h3, 8'h0A);
   endtask

   task automatic test_sweep();
      mon_en = 1'b1;
      for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i) ^ 8'h5A);
      for (int i = 0; i < 16; i++) do_read(4'(i), 8'(i) ^ 8'h5A);
      mon_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_fairness();
      test_reset_mid_read();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter SIZE_ADDR, 4, RAM address width.
REQ-002 SHALL have parameter SIZE_DATA, 8, RAM data width.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-004 SHALL have port i_clk  input  1  rising-edge clock.
REQ-005 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_wr_req  input  1  write requester: request, level, held until o_wr_ack.
REQ-007 SHALL have port i_wr_addr  input  SIZE_ADDR  write requester: address.
REQ-008 SHALL have port i_wr_data  input  SIZE_DATA  write requester: data.
REQ-009 SHALL have port o_wr_ack  output  1  write done, one-cycle pulse.
REQ-010 SHALL have port i_rd_req  input  1  read requester: request, level, held until o_rd_valid.
REQ-011 SHALL have port i_rd_addr  input  SIZE_ADDR  read requester: address.
REQ-012 SHALL have port o_rd_data  output  SIZE_DATA  read result, registered, stable until next read.
REQ-013 SHALL have port o_rd_valid  output  1  read result valid, one-cycle pulse.
REQ-014 SHALL have port o_ram_wr_en  output  1  RAM write strobe.
REQ-015 SHALL have port o_ram_rd_en  output  1  RAM read strobe.
REQ-016 SHALL have port o_ram_addr  output  SIZE_ADDR  RAM address.
REQ-017 SHALL have port o_ram_data  output  SIZE_DATA  RAM write data.
REQ-018 SHALL have port i_ram_data  input  SIZE_DATA  RAM read data (valid one cycle after the rd_en edge).
REQ-019 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ, RD_WAIT, RD_DONE.
REQ-021 SHALL, in IDLE at a clock edge with a request pending, latch the granted requester's address (and data for write) and move to WRITE or READ.
REQ-022 SHALL, when only one request is high, grant it.
REQ-023 SHALL, when both are high, grant the requester opposite to the last grant (round-robin).
REQ-024 SHALL update the last-grant flag on every grant.
REQ-025 SHALL, in WRITE, drive o_ram_wr_en=1, o_ram_addr/o_ram_data from the latched values and o_wr_ack=1 for exactly that cycle, then return to IDLE.
REQ-026 SHALL, in READ, drive o_ram_rd_en=1 and o_ram_addr from the latched value, then move to RD_WAIT.
REQ-027 SHALL, in RD_WAIT, register i_ram_data into o_rd_data at the exiting edge, then move to RD_DONE.
REQ-028 SHALL, in RD_DONE, drive o_rd_valid=1 for exactly that cycle, then return to IDLE.
REQ-029 SHALL produce write latency of 1 cycle after the grant edge (1 access per 2 cycles) and read latency of 3 cycles after the grant edge to o_rd_valid.
REQ-030 SHALL drive o_ram_wr_en, o_ram_rd_en, o_wr_ack and o_rd_valid as Moore outputs decoded from state only; they SHALL never be high together.
REQ-031 SHALL drive o_ram_addr and o_ram_data as 0 whenever no strobe is active.
REQ-032 SHALL complete a granted transaction even if its request drops before ack/valid.
REQ-033 SHALL ignore changes to address/data inputs after the grant edge.
REQ-034 SHALL, when a request remains high in the IDLE cycle after ack/valid, treat it as a new request.

Reset
REQ-035 SHALL, while i_rst=1, immediately force state=IDLE and all outputs to 0 (o_rd_data=0), with last-grant=read so that write wins the first conflict.
REQ-036 SHALL, when reset is asserted mid-transaction, abort it with no ack/valid; a WRITE aborted before its edge SHALL not commit.

Structure
REQ-037 SHALL take the state enum typedef and the grant enum (GNT_WR, GNT_RD) from shared package ram_arb_pkg.
REQ-038 SHALL place the two-way round-robin selection in sub-module rr_arbiter_2 (inputs: two requests, last grant; output: grant).

Verification
REQ-039 SHALL verify reset: i_rst=1 with both requests high -> all outputs 0, o_busy=0.
REQ-040 SHALL verify a single write (addr 3, data 0x0A) -> one cycle with o_ram_wr_en=1, o_ram_addr=3, o_ram_data=0x0A, o_wr_ack=1, coincident, 1 cycle after grant edge.
REQ-041 SHALL verify read-back of addr 3 -> o_ram_rd_en pulse with addr 3; o_rd_valid=1 with o_rd_data=0x0A exactly 3 cycles after grant; o_rd_data holds afterwards.
REQ-042 SHALL verify fairness: both requests held high after reset -> grant order W,R,W,R; the cycle-accurate strobe sequence is checked.
REQ-043 SHALL verify reset mid-read: i_rst pulsed during RD_WAIT -> o_rd_valid never asserted, FSM IDLE, a subsequent read of the same address succeeds.
REQ-044 SHALL verify a full sweep: write addr i with data i^0x5A for i=0..15, then read all 16 -> every o_rd_data matches and no strobe overlap occurs.
